// File: rtl/trig_pkg.sv
// trig_pkg: shared Q9.7 constants, CORDIC tables, fold encoding and FSM/divider types
// for the trig table writer.
package trig_pkg;

    // Q9.7 output format
    localparam int Q_W    = 16;
    localparam int Q_FRAC = 7;
    localparam int Q_ONE  = 1 << Q_FRAC;
    localparam int Q_RND  = 1 << (Q_FRAC - 1);
    localparam logic signed [Q_W-1:0] TRIG_SAT = 16'sd32767;

    // CORDIC datapath: x/y in Q2.14, z in binary-angle units (2^16 per turn)
    localparam int CORDIC_W = 18;
    localparam logic signed [CORDIC_W-1:0] CORDIC_K = 18'sd9949;

    // atan(2^-i) expressed in binary-angle units, 2^14 == pi/2
    localparam logic signed [CORDIC_W-1:0] ATAN_TAB [16] = '{
        18'sd8192, 18'sd4836, 18'sd2555, 18'sd1297,
        18'sd651,  18'sd326,  18'sd163,  18'sd81,
        18'sd41,   18'sd20,   18'sd10,   18'sd5,
        18'sd3,    18'sd1,    18'sd1,    18'sd0
    };

    // quadrant = angle[9:8]; selects how first-quadrant (s, c) map to (sin, cos)
    typedef enum logic [1:0] {QUAD_0, QUAD_1, QUAD_2, QUAD_3} quad_e;

    typedef enum logic [2:0] {
        S_IDLE, S_CORDIC, S_FOLD, S_DIV_TAN, S_DIV_COT, S_WRITE, S_DONE
    } state_e;

    typedef struct packed {
        logic signed [Q_W-1:0] num;
        logic signed [Q_W-1:0] den;
    } div_req_t;

    // saturated quotient for a zero divisor, signed like the numerator
    function automatic logic signed [Q_W-1:0] sat_sign(input logic signed [Q_W-1:0] v);
        return v[Q_W-1] ? -TRIG_SAT : TRIG_SAT;
    endfunction

endpackage

// File: rtl/trig_seq_div.sv
// trig_seq_div: 16-cycle signed-magnitude restoring divider, quotient truncated toward
// zero. A zero divisor skips the iterations and pulses done on the next cycle with
// div_zero set so the caller can substitute its saturated value.
module trig_seq_div
    import trig_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  div_req_t              req,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic signed [Q_W-1:0] quot
);

    logic [Q_W-1:0] acc, rem, dvs;
    logic [Q_W-1:0] acc_nx, rem_nx;
    logic [Q_W:0]   rem_sh;
    logic [3:0]     cnt;
    logic           neg;

    function automatic logic [Q_W-1:0] mag(input logic signed [Q_W-1:0] v);
        return v[Q_W-1] ? Q_W'(-v) : Q_W'(v);
    endfunction

    // one restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem, acc[Q_W-1]};
        if (rem_sh >= {1'b0, dvs}) begin
            rem_nx = Q_W'(rem_sh - {1'b0, dvs});
            acc_nx = {acc[Q_W-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[Q_W-1:0];
            acc_nx = {acc[Q_W-2:0], 1'b0};
        end
    end

    // operand capture, iteration count and sign restore on the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            quot     <= '0;
            acc      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                acc <= acc_nx;
                rem <= rem_nx;
                cnt <= cnt + 1'b1;
                if (cnt == 4'(Q_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    quot <= neg ? -signed'(acc_nx) : signed'(acc_nx);
                end
            end else if (start) begin
                neg <= req.num[Q_W-1] ^ req.den[Q_W-1];
                acc <= mag(req.num);
                dvs <= mag(req.den);
                rem <= '0;
                cnt <= '0;
                if (req.den == '0) begin
                    div_zero <= 1'b1;
                    done     <= 1'b1;
                    quot     <= '0;
                end else begin
                    div_zero <= 1'b0;
                    busy     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trig_table_writer.sv
// trig_table_writer: builds the 1024-entry {sin, cos, tan, cot} Q9.7 table through the
// BRAM write port. First-quadrant sin/cos come from an iterative CORDIC and are folded
// by quadrant; tan/cot reuse one sequential divider.
// Optional: TRIGGEN_CHECKSUM_EN adds a 64-bit XOR checksum of all written words.
module trig_table_writer
    import trig_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int CORDIC_ITERS = 14,
    parameter int INT_W        = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data
`ifdef TRIGGEN_CHECKSUM_EN
    ,
    output logic [63:0]       checksum
`endif
);

    state_e                   state;
    logic [ADDR_W-1:0]        angle, nxt_angle;
    logic [ADDR_W-3:0]        phase;
    quad_e                    quad;
    logic [ADDR_W+3:0]        z_now, z_nxt;
    logic signed [INT_W-1:0]  cx, cy, cz, xs, ys, cx_nx, cy_nx, cz_nx;
    logic [3:0]               it;
    logic signed [Q_W-1:0]    rnd_s, rnd_c, s1, c1, fs, fc;
    logic signed [Q_W-1:0]    sin_r, cos_r, tan_r, tan_v, cot_v;
    logic                     div_start, div_busy, div_done, div_zero;
    logic signed [Q_W-1:0]    div_q;
    div_req_t                 div_req;

    assign phase     = angle[ADDR_W-3:0];
    assign quad      = quad_e'(angle[ADDR_W-1 -: 2]);
    assign nxt_angle = angle + 1'b1;
    // phase step of one table entry is 64 binary-angle units
    assign z_now     = {phase, 6'b0};
    assign z_nxt     = {nxt_angle[ADDR_W-3:0], 6'b0};

    // one CORDIC micro-rotation toward z = 0
    always_comb begin
        xs = cx >>> it;
        ys = cy >>> it;
        if (!cz[INT_W-1]) begin
            cx_nx = cx - ys;
            cy_nx = cy + xs;
            cz_nx = cz - INT_W'(ATAN_TAB[it]);
        end else begin
            cx_nx = cx + ys;
            cy_nx = cy - xs;
            cz_nx = cz + INT_W'(ATAN_TAB[it]);
        end
    end

    // round Q2.14 to Q9.7 and map first-quadrant (s, c) into the full circle
    always_comb begin
        rnd_s = 16'((cy + INT_W'(Q_RND)) >>> Q_FRAC);
        rnd_c = 16'((cx + INT_W'(Q_RND)) >>> Q_FRAC);
        if (phase == '0) begin
            s1 = '0;
            c1 = Q_W'(Q_ONE);
        end else begin
            s1 = rnd_s;
            c1 = rnd_c;
        end
        fs = s1;
        fc = c1;
        case (quad)
            QUAD_0: begin fs = s1;  fc = c1;  end
            QUAD_1: begin fs = c1;  fc = -s1; end
            QUAD_2: begin fs = -s1; fc = -c1; end
            QUAD_3: begin fs = -c1; fc = s1;  end
            default: ;
        endcase
    end

    // divider result with the zero-divisor saturation applied
    always_comb begin
        tan_v = div_zero ? sat_sign(sin_r) : div_q;
        cot_v = div_zero ? sat_sign(cos_r) : div_q;
    end

    trig_seq_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .req      (div_req),
        .busy     (div_busy),
        .done     (div_done),
        .div_zero (div_zero),
        .quot     (div_q)
    );

    // table-build sequencer; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            angle       <= '0;
            cx          <= '0;
            cy          <= '0;
            cz          <= '0;
            it          <= '0;
            sin_r       <= '0;
            cos_r       <= '0;
            tan_r       <= '0;
            div_start   <= 1'b0;
            div_req     <= '0;
`ifdef TRIGGEN_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            done      <= 1'b0;
            wr_en     <= 1'b0;
            div_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        busy  <= 1'b1;
                        angle <= '0;
                        cx    <= INT_W'(CORDIC_K);
                        cy    <= '0;
                        cz    <= '0;
                        it    <= '0;
                        state <= S_CORDIC;
`ifdef TRIGGEN_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                S_CORDIC: begin
                    if (phase == '0) begin
                        state <= S_FOLD;
                    end else begin
                        cx <= cx_nx;
                        cy <= cy_nx;
                        cz <= cz_nx;
                        it <= it + 1'b1;
                        if (it == 4'(CORDIC_ITERS - 1))
                            state <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    sin_r       <= fs;
                    cos_r       <= fc;
                    div_req.num <= fs <<< Q_FRAC;
                    div_req.den <= fc;
                    div_start   <= 1'b1;
                    state       <= S_DIV_TAN;
                end
                S_DIV_TAN: begin
                    if (div_done && !div_busy) begin
                        tan_r       <= tan_v;
                        div_req.num <= cos_r <<< Q_FRAC;
                        div_req.den <= sin_r;
                        div_start   <= 1'b1;
                        state       <= S_DIV_COT;
                    end
                end
                S_DIV_COT: begin
                    if (div_done && !div_busy) begin
                        wr_en   <= 1'b1;
                        wr_addr <= angle;
                        wr_data <= {sin_r, cos_r, tan_r, cot_v};
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
`ifdef TRIGGEN_CHECKSUM_EN
                    checksum <= checksum ^ wr_data;
`endif
                    angle <= nxt_angle;
                    if (angle == '1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cx    <= INT_W'(CORDIC_K);
                        cy    <= '0;
                        cz    <= INT_W'(z_nxt);
                        it    <= '0;
                        state <= S_CORDIC;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // z_now is the load value at angle 0; kept for symmetry with z_nxt
    logic z_now_zero;
    assign z_now_zero = (z_now == '0);

endmodule

// File: tb/tb_trig_table_writer.sv
// tb_trig_table_writer: scoreboard bench. Each accepted start pushes the 1024 expected
// entries; a monitor pops one per wr_en and checks address order, exact quadrant
// words, +-1 LSB sin/cos against a real-valued model and tan/cot from the DUT's sin/cos.
module tb_trig_table_writer;

    localparam real PI      = 3.14159265358979323846;
    localparam int  TIMEOUT = 60000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
`ifdef TRIGGEN_CHECKSUM_EN
    logic [63:0] checksum;
    logic [63:0] first_sum;
`endif

    typedef struct {
        int          addr;
        bit          exact;
        logic [63:0] word;
        int          rs;
        int          rc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    bit          prev_we = 1'b0;
    logic [63:0] bench_xor = '0;
    bit          ok;

    trig_table_writer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
`ifdef TRIGGEN_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(input bit good, input string name,
                                  input longint act, input longint req);
        n_tests++;
        if (!good) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // (n<<7)/d truncated toward zero, saturated on a zero divisor
    function automatic int ratio(input int n, input int d);
        if (d == 0) return (n >= 0) ? 32767 : -32767;
        return (n * 128) / d;
    endfunction

    task automatic push_build();
        exp_q.delete();
        bench_xor = '0;
        for (int a = 0; a < 1024; a++) begin
            exp_t e;
            real  th;
            th      = 2.0 * PI * real'(a) / 1024.0;
            e.addr  = a;
            e.rs    = rnd(128.0 * $sin(th));
            e.rc    = rnd(128.0 * $cos(th));
            e.exact = (a % 256) == 0;
            case (a)
                0:       e.word = 64'h0000_0080_0000_7FFF;
                256:     e.word = 64'h0080_0000_7FFF_0000;
                512:     e.word = 64'h0000_FF80_0000_8001;
                768:     e.word = 64'hFF80_0000_8001_0000;
                default: e.word = '0;
            endcase
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_start();
        start = 1'b1;
        push_build();
        @(negedge clk);
        start = 1'b0;
        check(busy == 1'b1, "busy_after_start", busy, 1);
    endtask

    task automatic wait_write(input int a, output bit found);
        found = 1'b0;
        for (int n = 0; n < TIMEOUT && !found; n++) begin
            @(negedge clk);
            if (wr_en && int'(wr_addr) == a) found = 1'b1;
        end
        check(found, $sformatf("reach_write_%0d", a), found, 1);
    endtask

    task automatic wait_done(output bit found);
        found = 1'b0;
        for (int n = 0; n < TIMEOUT && !found; n++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check(found, "reach_done", found, 1);
    endtask

    // monitor: pops one expectation per write
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we = 1'b0;
            end else begin
                if (wr_en) begin
                    check(!prev_we, "wr_en_single_cycle", prev_we, 0);
                    check(busy == 1'b1, "busy_during_write", busy, 1);
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_write", wr_addr, -1);
                    end else begin
                        exp_t e;
                        int s, c, t, k;
                        e = exp_q.pop_front();
                        s = int'($signed(wr_data[63:48]));
                        c = int'($signed(wr_data[47:32]));
                        t = int'($signed(wr_data[31:16]));
                        k = int'($signed(wr_data[15:0]));
                        check(int'(wr_addr) == e.addr, "write_addr_order", wr_addr, e.addr);
                        if (e.exact) begin
                            check(wr_data == e.word, $sformatf("word_%0d", e.addr), wr_data, e.word);
                        end else begin
                            check((s - e.rs) <= 1 && (e.rs - s) <= 1,
                                  $sformatf("sin_%0d", e.addr), s, e.rs);
                            check((c - e.rc) <= 1 && (e.rc - c) <= 1,
                                  $sformatf("cos_%0d", e.addr), c, e.rc);
                            check(t == ratio(s, c), $sformatf("tan_%0d", e.addr), t, ratio(s, c));
                            check(k == ratio(c, s), $sformatf("cot_%0d", e.addr), k, ratio(c, s));
                        end
                        if (e.addr == 128) begin
                            check(s >= 90 && s <= 92, "sin_128_range", s, 91);
                            check(c >= 90 && c <= 92, "cos_128_range", c, 91);
                        end
                    end
                    bench_xor = bench_xor ^ wr_data;
                end
                if (done) done_cnt++;
                prev_we = wr_en;
            end
        end
    end

    // stimulus
    initial begin : stim
        repeat (3) @(negedge clk);
        check(busy == 1'b0,  "reset_busy",    busy, 0);
        check(done == 1'b0,  "reset_done",    done, 0);
        check(wr_en == 1'b0, "reset_wr_en",   wr_en, 0);
        check(wr_addr == '0, "reset_wr_addr", wr_addr, 0);
        check(wr_data == '0, "reset_wr_data", wr_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // first build, aborted by reset after entry 300
        issue_start();
        wait_write(300, ok);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check(wr_en == 1'b0, "midreset_wr_en",   wr_en, 0);
        check(busy == 1'b0,  "midreset_busy",    busy, 0);
        check(wr_addr == '0, "midreset_wr_addr", wr_addr, 0);
        check(done == 1'b0,  "midreset_done",    done, 0);
        rst = 1'b0;
        @(negedge clk);

        // full build from 0, with start pulses while busy that must be ignored
        done_cnt = 0;
        issue_start();
        wait_write(5, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_write(700, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        check(busy == 1'b0, "busy_at_done", busy, 0);
        check(exp_q.size() == 0, "all_writes_seen", 1024 - exp_q.size(), 1024);
`ifdef TRIGGEN_CHECKSUM_EN
        check(checksum == bench_xor, "checksum_build1", checksum, bench_xor);
        first_sum = checksum;
`endif
        @(negedge clk);
        check(done == 1'b0, "done_one_cycle", done, 0);
        repeat (3) @(negedge clk);
        check(done_cnt == 1, "done_pulse_count", done_cnt, 1);
        check(wr_en == 1'b0 && busy == 1'b0, "idle_after_done", {wr_en, busy}, 0);

`ifdef TRIGGEN_CHECKSUM_EN
        issue_start();
        wait_done(ok);
        check(checksum == bench_xor, "checksum_build2", checksum, bench_xor);
        check(checksum == first_sum, "checksum_repeat", checksum, first_sum);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_table_writer.md
Name: trig_table_writer

Overview:
- Populates the 1024-entry trig BRAM from its write port after reset.
- Each 64-bit word is {sin, cos, tan, cot}, each a signed 16-bit Q9.7 value; angles 0..1023 map onto 0..2π.
- Computes sin/cos with an iterative CORDIC, then tan/cot with a sequential divider.
- Sits beside the trig lookup read side. The renderer holds off until done; the table does not depend on a pre-baked memory image.

Parameters:
- ADDR_W, 10: address width; table depth = 2^ADDR_W (only 10 supported).
- CORDIC_ITERS, 14: CORDIC micro-rotations per entry (legal 12..16).
- INT_W, 18: CORDIC x/y/z datapath width; x/y use Q2.14 plus guard bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a full table build
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write
- wr_en  out  1  BRAM write enable, one cycle per entry
- wr_addr  out  10  BRAM write address
- wr_data  out  64  {sin[63:48], cos[47:32], tan[31:16], cot[15:0]}

Behaviour:
- Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0; FSM goes to IDLE.
- start handling:
  - Accepted only in IDLE or DONE.
  - Ignored while busy. It does not restart and is not queued.
- FSM: IDLE -> CORDIC -> FOLD -> DIV_TAN -> DIV_COT -> WRITE -> (next angle: CORDIC | last: DONE) -> IDLE.
- Angle decomposition: quadrant q = angle[9:8], phase p = angle[7:0].
- CORDIC (rotation mode):
  - Initial values: x = K·2^14 = 9949, y = 0, z = p scaled to the constant table units.
  - Runs exactly CORDIC_ITERS cycles.
  - If p == 0, CORDIC is bypassed: s=0, c=128 exactly.
- FOLD, 1 cycle:
  - Round Q2.14 to Q9.7 as (v + 64) >>> 7, giving first-quadrant s, c.
  - Quadrant mapping: q0 → (s, c); q1 → (c, −s); q2 → (−s, −c); q3 → (−c, s). Each pair is (sin, cos).
- Divider:
  - Signed, magnitude restoring, 16 cycles each.
  - tan = (sin<<7)/cos and cot = (cos<<7)/sin, truncated toward zero.
  - Magnitude never exceeds 16384, so no overflow.
- Zero-divisor rule:
  - cos==0 → tan = (sin≥0) ? +32767 : −32767.
  - sin==0 → cot = (cos≥0) ? +32767 : −32767.
  - The divider is skipped in that case; the state still advances on the next cycle.
- WRITE:
  - wr_en=1 for exactly one cycle, with wr_addr=angle and wr_data valid in that same cycle.
  - Addresses are strictly 0,1,…,1023, with no gaps or repeats.
- Angle wrap: after the write at 1023, the counter wraps to 0. The FSM then enters DONE: done=1 for one cycle, busy falls in that same cycle, then IDLE.
- Throughput: about 49 cycles per entry, about 50k cycles per build. Exact cycle counts are not contractual; the ordering and single-cycle wr_en are.
- Accuracy: sin/cos within ±1 LSB of round(128·sin/cos(2πa/1024)); exact at a ∈ {0,256,512,768}.
- Reset mid-build: outputs and FSM return to reset values on the next edge. The BRAM is left partially written; a new start rebuilds from 0.

Optional Feature:
- Macro: TRIGGEN_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[63:0], cleared on accepted start.
  - Each write XORs wr_data into it; the value is stable from the done pulse until the next start.
- Undefined: no port, no register; all other behaviour identical.

Decomposition:
- Shared package trig_pkg holds:
  - Q9.7 width/fraction constants.
  - TRIG_SAT = 16'sd32767.
  - CORDIC gain init (9949).
  - atan(2^-i) constant array (INT_W bits, 16 entries).
  - Quadrant-fold encoding.
  - FSM state typedef.
- One natural sub-module: trig_seq_div, the 16-cycle signed restoring divider with start/busy/done and zero-divisor flag; it is instantiated once and reused for tan then cot.

Test Plan:
- rst, then start pulse → first write wr_addr=0, wr_data={0, 128, 0, 32767} (0x0000_0080_0000_7FFF); busy=1 throughout; 1024 wr_en pulses total.
- Check entries 256/512/768 → {128,0,32767,0}, {0,−128,0,−32767}, {−128,0,−32767,0} exactly.
- Entry 128 → sin, cos ∈ [90,92], tan and cot = (x<<7)/y of those values; sweep all entries against a real-valued model (±1 LSB sin/cos, tan/cot recomputed from the DUT's sin/cos).
- start pulses while busy (at entries 5 and 700) → no restart; addresses stay monotonic; exactly one done.
- rst asserted at entry 300 → wr_en=0, busy=0, wr_addr=0 next cycle; a new start restarts the build from address 0.
- TRIGGEN_CHECKSUM_EN defined → checksum equals the bench XOR of all 1024 wr_data words at done; a second build gives the identical value.
